debounce_edge: RTL and testbench

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

---
 rtl/debounce_edge_if.sv | 13 +
 rtl/debounce_edge.sv | 113 +++++++++++
 tb/tb_debounce_edge.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/debounce_edge_if.sv
// Signal bundle between the upstream synchroniser and the debounce_edge block.
interface debounce_edge_if;
  localparam int unsigned RISE_CNT_W = 16;

  logic                  in;
  logic                  level;
  logic                  rise;
  logic                  fall;
  logic [RISE_CNT_W-1:0] rise_cnt;

  modport master (output in, input level, input rise, input fall, input rise_cnt);
  modport slave  (input in, output level, output rise, output fall, output rise_cnt);
endinterface

// File: rtl/debounce_edge.sv
// Debouncer with registered level and one-cycle rise/fall pulses.
// Define DEBOUNCE_EDGE_RISE_CNT_EN to add a saturating count of accepted rises.
module debounce_edge #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  debounce_edge_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {LOW, WAIT_H, HIGH, WAIT_L} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Next-state logic; cnt only counts while qualifying and returns to zero otherwise
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      LOW: begin
        if (bus.in) begin
          state_d = WAIT_H;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_H: begin
        if (!bus.in) begin
          state_d = LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!bus.in) begin
          state_d = WAIT_L;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_L: begin
        if (bus.in) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = LOW;
    endcase
    level_d = (state_d == HIGH) || (state_d == WAIT_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.level = level_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;

`ifdef DEBOUNCE_EDGE_RISE_CNT_EN
  localparam int unsigned RCNT_W = 16;

  logic [RCNT_W-1:0] rise_cnt_q, rise_cnt_d;

  // Counts together with the rise pulse so rise_cnt already includes it
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    if (rise_d && (rise_cnt_q != {RCNT_W{1'b1}})) begin
      rise_cnt_d = rise_cnt_q + RCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt_q <= '0;
    end else begin
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign bus.rise_cnt = rise_cnt_q;
`else
  assign bus.rise_cnt = '0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: directed table, reset corners, random runs.
module tb_debounce_edge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debounce_edge_if b0 ();
  debounce_edge_if b1 ();

  debounce_edge #(.CNT_W(16), .STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  debounce_edge #(.CNT_W(1), .STABLE_CYCLES(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  // Reference: a new level is accepted once `in` has differed from it for s edges in a row
  typedef struct {
    bit level;
    int run;
    bit rise;
    bit fall;
    int rcnt;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, bit v, int s);
    m.rise = 1'b0;
    m.fall = 1'b0;
    if (v != m.level) m.run = m.run + 1;
    else              m.run = 0;
    if (m.run == s) begin
      m.level = v;
      m.run   = 0;
      if (v) begin
        m.rise = 1'b1;
        if (m.rcnt < 65535) m.rcnt = m.rcnt + 1;
      end else begin
        m.fall = 1'b1;
      end
    end
    return m;
  endfunction

  typedef struct {
    bit in;
    bit lvl;
    bit rise;
    bit fall;
  } vec_t;

  vec_t vq[$];
  mdl_t m0, m1;
  int   tog;
  bit   prev0, prev1;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rcnt(int r);
`ifdef DEBOUNCE_EDGE_RISE_CNT_EN
    return 32'(r);
`else
    return 32'(r * 0);
`endif
  endfunction

  task automatic cmp_models();
    check("lvl0", 32'(b0.level), 32'(m0.level));
    check("rise0", 32'(b0.rise), 32'(m0.rise));
    check("fall0", 32'(b0.fall), 32'(m0.fall));
    check("rcnt0", 32'(b0.rise_cnt), exp_rcnt(m0.rcnt));
    check("excl0", 32'(b0.rise & b0.fall), 32'd0);
    check("gap0", 32'((b0.rise | b0.fall) & prev0), 32'd0);
    prev0 = b0.rise | b0.fall;
    check("lvl1", 32'(b1.level), 32'(m1.level));
    check("rise1", 32'(b1.rise), 32'(m1.rise));
    check("fall1", 32'(b1.fall), 32'(m1.fall));
    check("rcnt1", 32'(b1.rise_cnt), exp_rcnt(m1.rcnt));
    check("gap1", 32'((b1.rise | b1.fall) & prev1), 32'd0);
    prev1 = b1.rise | b1.fall;
  endtask

  // One clock: drive, let both models step on the edge, compare on the falling edge
  task automatic tick(input bit v);
    bit v1;
    v1 = ((tog / 2) % 2) == 0;
    b0.in = v;
    b1.in = v1;
    tog++;
    @(posedge clk);
    m0 = mdl_step(m0, v, 4);
    m1 = mdl_step(m1, v1, 2);
    @(negedge clk);
    cmp_models();
  endtask

  task automatic reset_models();
    m0 = '{default: 0};
    m1 = '{default: 0};
    tog = 0;
    prev0 = 1'b0;
    prev1 = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    reset_models();
  endtask

  initial begin
    vec_t v;
    // in, level, rise, fall after each edge (STABLE_CYCLES=4)
    repeat (3) vq.push_back('{1, 0, 0, 0});
    vq.push_back('{1, 1, 1, 0});
    vq.push_back('{1, 1, 0, 0});
    repeat (3) vq.push_back('{0, 1, 0, 0});
    vq.push_back('{0, 0, 0, 1});
    vq.push_back('{0, 0, 0, 0});
    repeat (3) vq.push_back('{1, 0, 0, 0});
    vq.push_back('{0, 0, 0, 0});
    repeat (3) vq.push_back('{1, 0, 0, 0});
    vq.push_back('{1, 1, 1, 0});
    repeat (3) vq.push_back('{0, 1, 0, 0});
    vq.push_back('{1, 1, 0, 0});
    repeat (3) vq.push_back('{0, 1, 0, 0});
    vq.push_back('{0, 0, 0, 1});

    b0.in = 1'b0;
    b1.in = 1'b0;
    reset_models();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_level", 32'(b0.level), 32'd0);
    check("rst_rise", 32'(b0.rise), 32'd0);
    check("rst_fall", 32'(b0.fall), 32'd0);
    check("rst_rcnt", 32'(b0.rise_cnt), 32'd0);
    check("rst_cnt", 32'(dut.cnt_q), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      tick(v.in);
      check($sformatf("vec%0d_level", i), 32'(b0.level), 32'(v.lvl));
      check($sformatf("vec%0d_rise", i), 32'(b0.rise), 32'(v.rise));
      check($sformatf("vec%0d_fall", i), 32'(b0.fall), 32'(v.fall));
    end

    // Reset in WAIT_H with cnt=3 clears progress without any edge
    repeat (3) tick(1'b1);
    check("waith_cnt3", 32'(dut.cnt_q), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_level", 32'(b0.level), 32'd0);
    check("async_rise", 32'(b0.rise), 32'd0);
    check("async_cnt", 32'(dut.cnt_q), 32'd0);
    @(posedge clk);
    release_reset();
    repeat (3) begin
      tick(1'b1);
      check("post_rst_no_rise", 32'(b0.rise), 32'd0);
    end
    tick(1'b1);
    check("post_rst_rise", 32'(b0.rise), 32'd1);
    check("post_rst_level", 32'(b0.level), 32'd1);

    // Reset while the rise pulse is visible drops it immediately
    #1 rst_n = 1'b0;
    #1;
    check("async_drop_rise", 32'(b0.rise), 32'd0);
    check("async_drop_level", 32'(b0.level), 32'd0);
    release_reset();

    // Randomised runs of random length
    for (int s = 0; s < 300; s++) begin
      bit rv;
      int len;
      rv  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      repeat (len) tick(rv);
    end

`ifdef DEBOUNCE_EDGE_RISE_CNT_EN
    rst_n = 1'b0;
    release_reset();
    repeat (5) begin
      repeat (4) tick(1'b1);
      repeat (4) tick(1'b0);
    end
    check("rcnt_five", 32'(b0.rise_cnt), 32'd5);
    force dut.rise_cnt_q = 16'hFFFF;
    #1;
    release dut.rise_cnt_q;
    m0.rcnt = 65535;
    repeat (4) tick(1'b1);
    check("rcnt_sat", 32'(b0.rise_cnt), 32'h0000FFFF);
`else
    check("rcnt_off", 32'(b0.rise_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
